dds_and_hilbert: RTL and testbench

//  Single-tone generator with analytic-pair combining: a 24-bit phase-accumulator DDS drives a sine ROM.
//  A 15-tap FIR Hilbert transformer then derives the quadrature component Q.
//  The time-aligned in-phase sample I and Q are summed into a 17-bit single-sideband style output.

---
 rtl/dds_and_hilbert.sv | 126 ++++++++++++
 tb/tb_dds_and_hilbert.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dds_and_hilbert.sv
// Phase-accumulator DDS into a sine table, 15-tap Hilbert FIR for Q, OUT = I + Q (upper sideband).
// Define DDS_LSB_EN to build OUT = I - Q (lower sideband); default build leaves it undefined.
module dds_and_hilbert #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 10,
    parameter int SMP_W   = 16,
    parameter int OUT_W   = 17
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENB,
    input  logic [PHASE_W-1:0] SET_FREQ,
    output logic [OUT_W-1:0]   OUT
);
    localparam int TAPS   = 15;
    localparam int MID    = 7;
    localparam int ACC_W  = 36;
    localparam int COEF_W = 16;
    localparam int FRAC   = 15;
    localparam int ROM_D  = 1 << ADDR_W;

    localparam logic signed [COEF_W-1:0] C1 = 16'sd19910;
    localparam logic signed [COEF_W-1:0] C3 = 16'sd4467;
    localparam logic signed [COEF_W-1:0] C5 = 16'sd1056;
    localparam logic signed [COEF_W-1:0] C7 = 16'sd238;

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SMP_MAX  = ACC_W'((1 << (SMP_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMP_MIN  = ACC_W'(-(1 << (SMP_W - 1)));

    // Table entries are fixed at elaboration: round(32767*sin(2*pi*p/1024)), half away from zero.
    function automatic logic signed [SMP_W-1:0] sine_entry(input int p);
        real r;
        int  v;
        r = real'((1 << (SMP_W - 1)) - 1) * $sin(2.0 * 3.14159265358979323846 * real'(p) / real'(ROM_D));
        v = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
        return v[SMP_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] tap_pair(input logic signed [COEF_W-1:0] c,
                                                         input logic signed [SMP_W-1:0]  a,
                                                         input logic signed [SMP_W-1:0]  b);
        logic signed [ACC_W-1:0] diff;
        diff = ACC_W'(a) - ACC_W'(b);
        return ACC_W'(c) * diff;
    endfunction

    function automatic logic signed [SMP_W-1:0] round_sat(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = (s + RND_HALF) >>> FRAC;
        if (r > SMP_MAX) begin
            return SMP_MAX[SMP_W-1:0];
        end else if (r < SMP_MIN) begin
            return SMP_MIN[SMP_W-1:0];
        end
        return r[SMP_W-1:0];
    endfunction

    logic signed [SMP_W-1:0] rom [ROM_D];

    for (genvar p = 0; p < ROM_D; p++) begin : g_rom
        assign rom[p] = sine_entry(p);
    end

    logic        [PHASE_W-1:0] acc_p0_q, acc_p0_d;
    logic signed [SMP_W-1:0]   dly_p1_q [TAPS];
    logic signed [SMP_W-1:0]   dly_p1_d [TAPS];
    logic signed [SMP_W-1:0]   q_p2_q, q_p2_d;
    logic signed [SMP_W-1:0]   i_p2_q, i_p2_d;
    logic signed [OUT_W-1:0]   out_p3_q, out_p3_d;
    logic signed [ACC_W-1:0]   fir_sum;

    // Antisymmetric taps about d[7]; even-offset taps are zero and omitted.
    always_comb begin
        fir_sum = tap_pair(C1, dly_p1_q[8],  dly_p1_q[6])
                + tap_pair(C3, dly_p1_q[10], dly_p1_q[4])
                + tap_pair(C5, dly_p1_q[12], dly_p1_q[2])
                + tap_pair(C7, dly_p1_q[14], dly_p1_q[0]);
    end

    always_comb begin
        acc_p0_d = acc_p0_q;
        dly_p1_d = dly_p1_q;
        q_p2_d   = q_p2_q;
        i_p2_d   = i_p2_q;
        out_p3_d = out_p3_q;
        if (ENB) begin
            // p0 -> p1: phase step and table read; d[0] is the registered sample
            acc_p0_d    = acc_p0_q + SET_FREQ;
            dly_p1_d[0] = rom[acc_p0_q[PHASE_W-1 -: ADDR_W]];
            for (int k = 1; k < TAPS; k++) begin
                dly_p1_d[k] = dly_p1_q[k-1];
            end
            // p1 -> p2: Q and the centre tap I captured together
            q_p2_d = round_sat(fir_sum);
            i_p2_d = dly_p1_q[MID];
            // p2 -> p3: sideband combine, 17 bits cannot overflow
`ifdef DDS_LSB_EN
            out_p3_d = OUT_W'(i_p2_q) - OUT_W'(q_p2_q);
`else
            out_p3_d = OUT_W'(i_p2_q) + OUT_W'(q_p2_q);
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_p0_q <= '0;
            for (int k = 0; k < TAPS; k++) begin
                dly_p1_q[k] <= '0;
            end
            q_p2_q   <= '0;
            i_p2_q   <= '0;
            out_p3_q <= '0;
        end else begin
            acc_p0_q <= acc_p0_d;
            dly_p1_q <= dly_p1_d;
            q_p2_q   <= q_p2_d;
            i_p2_q   <= i_p2_d;
            out_p3_q <= out_p3_d;
        end
    end

    assign OUT = out_p3_q;

endmodule

// File: tb/tb_dds_and_hilbert.sv
// Directed bench for dds_and_hilbert: reset/enable behaviour, zero tuning word, fs/4 pattern,
// a low tone against a direct-form reference, enable gap, async reset and an aliased tuning word.
module tb_dds_and_hilbert;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ENB = 1'b0;
    logic [23:0] SET_FREQ = '0;
    logic [16:0] OUT;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef DDS_LSB_EN
    localparam int SGN = -1;
`else
    localparam int SGN = 1;
`endif
    localparam longint F_TONE = 40097;
    localparam longint F_FS4  = 64'd1 << 22;

    dds_and_hilbert dut (
        .CLK      (CLK),
        .RST      (RST),
        .ENB      (ENB),
        .SET_FREQ (SET_FREQ),
        .OUT      (OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int out_s();
        return int'($signed(OUT));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int sine_ref(input longint p);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 1024.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    endfunction

    // Sample fed by the phase after j enabled edges from a cleared accumulator.
    function automatic longint samp(input longint f, input int j);
        if (j < 0) return 0;
        return longint'(sine_ref(((f * j) & 64'hFF_FFFF) >> 14));
    endfunction

    // OUT after m enabled edges: sample j reaches d[k] when OUT uses j = m-3-k.
    function automatic int exp_out(input longint f, input int m);
        longint s, q, i;
        s = 19910 * (samp(f, m-11) - samp(f, m-9))
          +  4467 * (samp(f, m-13) - samp(f, m-7))
          +  1056 * (samp(f, m-15) - samp(f, m-5))
          +   238 * (samp(f, m-17) - samp(f, m-3));
        q = (s + 16384) >>> 15;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        i = samp(f, m-10);
        return int'(i + SGN * q);
    endfunction

    initial begin
        int first_vals [7];
        int fs4_tab [4];
        int hold;
        first_vals = '{0, 0, 0, -3, -6, -23, -39};
`ifdef DDS_LSB_EN
        fs4_tab = '{-32521, -32767, 32521, 32767};
`else
        fs4_tab = '{32521, -32767, -32521, 32767};
`endif

        RST = 1'b0; ENB = 1'b1; SET_FREQ = 24'(F_TONE);
        repeat (3) begin
            tick();
            chk_eq("rst_hold", out_s(), 0);
        end
        RST = 1'b1; ENB = 1'b0;
        repeat (3) begin
            tick();
            chk_eq("enb_low_after_release", out_s(), 0);
        end

        SET_FREQ = '0; ENB = 1'b1;
        repeat (30) begin
            tick();
            chk_eq("freq_zero", out_s(), 0);
        end

        SET_FREQ = 24'(F_TONE);
        for (int m = 1; m <= 7; m++) begin
            tick();
            chk_eq($sformatf("first_samples_m%0d", m), out_s(), SGN * first_vals[m-1]);
        end
        for (int m = 8; m <= 600; m++) begin
            tick();
            chk_eq($sformatf("tone_m%0d", m), out_s(), exp_out(F_TONE, m));
        end

        hold = exp_out(F_TONE, 600);
        ENB = 1'b0; SET_FREQ = 24'h12_3456;
        repeat (5) begin
            tick();
            chk_eq("enb_gap_hold", out_s(), hold);
        end
        ENB = 1'b1; SET_FREQ = 24'(F_TONE);
        for (int m = 601; m <= 700; m++) begin
            tick();
            chk_eq($sformatf("enb_resume_m%0d", m), out_s(), exp_out(F_TONE, m));
        end

        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk_eq("async_rst_immediate", out_s(), 0);
        tick();
        chk_eq("async_rst_held", out_s(), 0);
        RST = 1'b1;
        for (int m = 1; m <= 450; m++) begin
            tick();
            chk_eq($sformatf("restart_m%0d", m), out_s(), exp_out(F_TONE, m));
        end

        RST = 1'b0;
        tick();
        RST = 1'b1; SET_FREQ = 24'(F_FS4);
        for (int m = 1; m <= 40; m++) begin
            tick();
            if (m >= 17) chk_eq($sformatf("fs4_m%0d", m), out_s(), fs4_tab[m % 4]);
        end

        RST = 1'b0;
        tick();
        RST = 1'b1; SET_FREQ = 24'(3 * F_FS4);
        for (int m = 1; m <= 40; m++) begin
            tick();
            chk_eq($sformatf("alias_m%0d", m), out_s(), exp_out(3 * F_FS4, m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
